// File: rtl/vex_l15_arb_transducer.sv
// VexRiscv iBus/dBus to OpenPiton L1.5 bridge.
// Arbitrates between the two Vex command ports, holds one L1.5 request
// outstanding, and routes the response back by a latched channel tag.
module vex_l15_arb_transducer #(
  parameter int ADDR_WIDTH    = 40,
  parameter bit DBUS_PRIORITY = 1'b0,
  parameter int NC_BIT        = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ibus_cmd_valid,
  input  logic [31:0]           ibus_cmd_pc,
  output logic                  ibus_cmd_ready,
  output logic                  ibus_rsp_valid,
  output logic [31:0]           ibus_rsp_inst,
  output logic                  ibus_rsp_error,
  input  logic                  dbus_cmd_valid,
  input  logic                  dbus_cmd_wr,
  input  logic [31:0]           dbus_cmd_address,
  input  logic [31:0]           dbus_cmd_data,
  input  logic [1:0]            dbus_cmd_size,
  output logic                  dbus_cmd_ready,
  output logic                  dbus_rsp_valid,
  output logic [31:0]           dbus_rsp_data,
  output logic                  dbus_rsp_error,
  output logic                  transducer_l15_val,
  output logic [4:0]            transducer_l15_rqtype,
  output logic [2:0]            transducer_l15_size,
  output logic [ADDR_WIDTH-1:0] transducer_l15_address,
  output logic [63:0]           transducer_l15_data,
  output logic                  transducer_l15_nc,
  output logic [3:0]            transducer_l15_amo_op,
  input  logic                  l15_transducer_ack,
  input  logic                  l15_transducer_val,
  input  logic [3:0]            l15_transducer_returntype,
  input  logic [63:0]           l15_transducer_data_0,
  input  logic [63:0]           l15_transducer_data_1,
  output logic                  transducer_l15_req_ack,
  output logic                  vex_int
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [4:0] LOAD_RQ     = 5'b00000;
  localparam logic [4:0] STORE_RQ    = 5'b00001;
  localparam logic [2:0] PCX_SZ_1B   = 3'b000;
  localparam logic [2:0] PCX_SZ_2B   = 3'b001;
  localparam logic [2:0] PCX_SZ_4B   = 3'b010;
  localparam logic [3:0] LOAD_RET    = 4'b0000;
  localparam logic [3:0] ST_ACK      = 4'b0100;
  localparam logic [3:0] INT_RET     = 4'b0111;
  localparam logic [3:0] AMO_OP_NONE = 4'b0000;

  localparam logic CH_IBUS = 1'b0;
  localparam logic CH_DBUS = 1'b1;

  logic [1:0]  state;
  logic        last_grant;
  logic        chan_q;
  logic        wr_q;
  logic [1:0]  word_sel_q;
  logic        grant_i;
  logic        grant_d;
  logic [31:0] sel_addr;
  logic        dbus_bad;
  logic        rsp_match;
  logic        done;
  logic [31:0] rsp_word;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign transducer_l15_amo_op  = AMO_OP_NONE;
  assign transducer_l15_req_ack = l15_transducer_val;
  assign ibus_rsp_error         = 1'b0;

  // Arbitration: only in IDLE; tie goes to dBus or to the channel not granted last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n && state == IDLE) begin
      if (ibus_cmd_valid && dbus_cmd_valid) begin
        if (DBUS_PRIORITY || last_grant == CH_IBUS) grant_d = 1'b1;
        else                                        grant_i = 1'b1;
      end else begin
        grant_i = ibus_cmd_valid;
        grant_d = dbus_cmd_valid;
      end
    end
  end

  assign ibus_cmd_ready = grant_i;
  assign dbus_cmd_ready = grant_d;

  // Command decode, response matching and load-word selection.
  always_comb begin
    sel_addr  = grant_d ? dbus_cmd_address : ibus_cmd_pc;
    dbus_bad  = (dbus_cmd_size == 2'd3) ||
                (dbus_cmd_size == 2'd1 && dbus_cmd_address[0]) ||
                (dbus_cmd_size == 2'd2 && dbus_cmd_address[1:0] != 2'b00);
    rsp_match = l15_transducer_val &&
                (l15_transducer_returntype == LOAD_RET || l15_transducer_returntype == ST_ACK);
    done      = rsp_match && ((state == REQ && l15_transducer_ack) || state == RSP);
    case (word_sel_q)
      2'd0:    rsp_word = l15_transducer_data_0[63:32];
      2'd1:    rsp_word = l15_transducer_data_0[31:0];
      2'd2:    rsp_word = l15_transducer_data_1[63:32];
      default: rsp_word = l15_transducer_data_1[31:0];
    endcase
  end

  // Transaction FSM, registered L1.5 request fields and Vex response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      last_grant             <= CH_IBUS;
      chan_q                 <= CH_IBUS;
      wr_q                   <= 1'b0;
      word_sel_q             <= '0;
      transducer_l15_val     <= 1'b0;
      transducer_l15_rqtype  <= '0;
      transducer_l15_size    <= '0;
      transducer_l15_address <= '0;
      transducer_l15_data    <= '0;
      transducer_l15_nc      <= 1'b0;
      ibus_rsp_valid         <= 1'b0;
      ibus_rsp_inst          <= '0;
      dbus_rsp_valid         <= 1'b0;
      dbus_rsp_data          <= '0;
      dbus_rsp_error         <= 1'b0;
    end else begin
      ibus_rsp_valid <= 1'b0;
      ibus_rsp_inst  <= '0;
      dbus_rsp_valid <= 1'b0;
      dbus_rsp_data  <= '0;
      dbus_rsp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            chan_q                 <= grant_d;
            last_grant             <= grant_d;
            wr_q                   <= grant_d && dbus_cmd_wr;
            word_sel_q             <= sel_addr[3:2];
            transducer_l15_rqtype  <= (grant_d && dbus_cmd_wr) ? STORE_RQ : LOAD_RQ;
            transducer_l15_address <= {{(ADDR_WIDTH-32){sel_addr[31]}}, sel_addr};
            transducer_l15_nc      <= sel_addr[NC_BIT];
            transducer_l15_data    <= (grant_d && dbus_cmd_wr) ?
                                      {swap32(dbus_cmd_data), swap32(dbus_cmd_data)} : '0;
            if (!grant_d)                  transducer_l15_size <= PCX_SZ_4B;
            else if (dbus_cmd_size == 2'd0) transducer_l15_size <= PCX_SZ_1B;
            else if (dbus_cmd_size == 2'd1) transducer_l15_size <= PCX_SZ_2B;
            else                            transducer_l15_size <= PCX_SZ_4B;
            if (grant_d && dbus_bad) begin
              state <= ERR;
            end else begin
              state              <= REQ;
              transducer_l15_val <= 1'b1;
            end
          end
        end
        REQ: begin
          if (l15_transducer_ack) begin
            transducer_l15_val <= 1'b0;
            state              <= rsp_match ? IDLE : RSP;
          end
        end
        RSP: begin
          if (rsp_match) state <= IDLE;
        end
        default: begin
          dbus_rsp_valid <= 1'b1;
          dbus_rsp_error <= 1'b1;
          state          <= IDLE;
        end
      endcase
      // Completion is shared by RSP and the REQ same-cycle ack+response path.
      if (done) begin
        if (chan_q == CH_DBUS) begin
          dbus_rsp_valid <= 1'b1;
          dbus_rsp_data  <= wr_q ? '0 : swap32(rsp_word);
        end else begin
          ibus_rsp_valid <= 1'b1;
          ibus_rsp_inst  <= swap32(rsp_word);
        end
      end
    end
  end

  // Wakeup interrupt pulse, independent of the transaction FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vex_int <= 1'b0;
    else        vex_int <= l15_transducer_val && l15_transducer_returntype == INT_RET &&
                           l15_transducer_data_0[17:16] == 2'b01;
  end

endmodule

// File: tb/tb_vex_l15_arb_transducer.sv
// Directed scoreboard bench for vex_l15_arb_transducer.
module tb_vex_l15_arb_transducer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_cmd_valid = 1'b0;
  logic [31:0] ibus_cmd_pc = '0;
  logic        dbus_cmd_valid = 1'b0;
  logic        dbus_cmd_wr = 1'b0;
  logic [31:0] dbus_cmd_address = '0;
  logic [31:0] dbus_cmd_data = '0;
  logic [1:0]  dbus_cmd_size = '0;
  logic        l15_ack = 1'b0;
  logic        l15_val = 1'b0;
  logic [3:0]  l15_rt = '0;
  logic [63:0] l15_d0 = '0;
  logic [63:0] l15_d1 = '0;

  logic        ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_rsp_inst;
  logic        dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        t_val, t_nc, req_ack, vex_int;
  logic [4:0]  t_rqtype;
  logic [2:0]  t_size;
  logic [39:0] t_addr;
  logic [63:0] t_data;
  logic [3:0]  t_amo;

  logic        p_ibus_cmd_ready, p_ibus_rsp_valid, p_ibus_rsp_error;
  logic [31:0] p_ibus_rsp_inst;
  logic        p_dbus_cmd_ready, p_dbus_rsp_valid, p_dbus_rsp_error;
  logic [31:0] p_dbus_rsp_data;
  logic        p_t_val, p_t_nc, p_req_ack, p_vex_int;
  logic [4:0]  p_t_rqtype;
  logic [2:0]  p_t_size;
  logic [39:0] p_t_addr;
  logic [63:0] p_t_data;
  logic [3:0]  p_t_amo;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;

  always #5 clk = ~clk;

  vex_l15_arb_transducer #(.ADDR_WIDTH(40), .DBUS_PRIORITY(1'b0), .NC_BIT(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_pc(ibus_cmd_pc), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_inst(ibus_rsp_inst), .ibus_rsp_error(ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_error(dbus_rsp_error),
    .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rqtype), .transducer_l15_size(t_size),
    .transducer_l15_address(t_addr), .transducer_l15_data(t_data), .transducer_l15_nc(t_nc),
    .transducer_l15_amo_op(t_amo), .l15_transducer_ack(l15_ack), .l15_transducer_val(l15_val),
    .l15_transducer_returntype(l15_rt), .l15_transducer_data_0(l15_d0), .l15_transducer_data_1(l15_d1),
    .transducer_l15_req_ack(req_ack), .vex_int(vex_int)
  );

  vex_l15_arb_transducer #(.ADDR_WIDTH(40), .DBUS_PRIORITY(1'b1), .NC_BIT(31)) dut_pri (
    .clk(clk), .rst_n(rst_n),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_pc(ibus_cmd_pc), .ibus_cmd_ready(p_ibus_cmd_ready),
    .ibus_rsp_valid(p_ibus_rsp_valid), .ibus_rsp_inst(p_ibus_rsp_inst), .ibus_rsp_error(p_ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(p_dbus_cmd_ready),
    .dbus_rsp_valid(p_dbus_rsp_valid), .dbus_rsp_data(p_dbus_rsp_data), .dbus_rsp_error(p_dbus_rsp_error),
    .transducer_l15_val(p_t_val), .transducer_l15_rqtype(p_t_rqtype), .transducer_l15_size(p_t_size),
    .transducer_l15_address(p_t_addr), .transducer_l15_data(p_t_data), .transducer_l15_nc(p_t_nc),
    .transducer_l15_amo_op(p_t_amo), .l15_transducer_ack(l15_ack), .l15_transducer_val(l15_val),
    .l15_transducer_returntype(l15_rt), .l15_transducer_data_0(l15_d0), .l15_transducer_data_1(l15_d1),
    .transducer_l15_req_ack(p_req_ack), .vex_int(p_vex_int)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [31:0] data, input logic err);
    exp_t e;
    e.ch = ch; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  // Response monitor: every rsp pulse on the round-robin instance pops one expectation.
  always @(negedge clk) begin
    if (rst_n && (ibus_rsp_valid || dbus_rsp_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {dbus_rsp_valid, ibus_rsp_valid}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_chan", {dbus_rsp_valid, ibus_rsp_valid}, mon_e.ch);
        chk("rsp_data", dbus_rsp_valid ? dbus_rsp_data : ibus_rsp_inst, mon_e.data);
        chk("rsp_err", dbus_rsp_valid ? dbus_rsp_error : ibus_rsp_error, mon_e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0]  err_size [3];
    logic [31:0] err_addr [3];
    logic        expd;
    err_size = '{2'd2, 2'd1, 2'd3};
    err_addr = '{32'h2, 32'h1, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_l15_val", t_val, 0);
    chk("rst_rqtype", t_rqtype, 0);
    chk("rst_addr", t_addr, 0);
    chk("rst_data", t_data, 0);
    chk("rst_amo", t_amo, 0);
    chk("rst_vex_int", vex_int, 0);
    chk("rst_rsp", {ibus_rsp_valid, dbus_rsp_valid}, 0);
    rst_n = 1'b1;

    // iBus fetch, separate ack and LOAD_RET, word 2 selected by pc[3:2]
    @(negedge clk);
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_1008;
    #1 chk("f_iready", ibus_cmd_ready, 1);
    chk("f_dready", dbus_cmd_ready, 0);
    push_exp(2'b01, 32'hDDCCBBAA, 1'b0);
    @(negedge clk);
    chk("f_iready_busy", ibus_cmd_ready, 0);
    ibus_cmd_valid = 1'b0;
    chk("f_val", t_val, 1);
    chk("f_rqtype", t_rqtype, 5'b00000);
    chk("f_size", t_size, 3'b010);
    chk("f_addr", t_addr, 40'h00_0000_1008);
    chk("f_nc", t_nc, 0);
    chk("f_data", t_data, 0);
    l15_ack = 1'b1;
    @(negedge clk);
    l15_ack = 1'b0;
    chk("f_val_drop", t_val, 0);
    l15_val = 1'b1; l15_rt = 4'd0;
    l15_d0 = 64'h11223344_AABBCCDD; l15_d1 = 64'hAABBCCDD_55667788;
    #1 chk("f_req_ack", req_ack, 1);
    @(negedge clk);
    l15_val = 1'b0;
    @(negedge clk);
    chk("f_pulse_1cyc", ibus_rsp_valid, 0);
    chk("f_sb_empty", sb.size(), 0);

    // dBus store, same-cycle ack and ST_ACK
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1; dbus_cmd_address = 32'h8000_0004;
    dbus_cmd_data = 32'h1234_5678; dbus_cmd_size = 2'd2;
    #1 chk("s_dready", dbus_cmd_ready, 1);
    push_exp(2'b10, 32'h0, 1'b0);
    @(negedge clk);
    dbus_cmd_valid = 1'b0;
    chk("s_val", t_val, 1);
    chk("s_rqtype", t_rqtype, 5'b00001);
    chk("s_nc", t_nc, 1);
    chk("s_addr", t_addr, 40'hFF_8000_0004);
    chk("s_data", t_data, 64'h78563412_78563412);
    chk("s_size", t_size, 3'b010);
    l15_ack = 1'b1; l15_val = 1'b1; l15_rt = 4'd4;
    @(negedge clk);
    l15_ack = 1'b0; l15_val = 1'b0;
    chk("s_val_drop", t_val, 0);
    @(negedge clk);
    chk("s_sb_empty", sb.size(), 0);

    // Illegal/misaligned dBus commands go through ERR without an L1.5 request
    for (int k = 0; k < 3; k++) begin
      dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0;
      dbus_cmd_address = err_addr[k]; dbus_cmd_size = err_size[k];
      #1 chk("e_dready", dbus_cmd_ready, 1);
      push_exp(2'b10, 32'h0, 1'b1);
      @(negedge clk);
      dbus_cmd_valid = 1'b0;
      chk("e_no_val", t_val, 0);
      chk("e_no_rsp_yet", dbus_rsp_valid, 0);
      @(negedge clk);
      chk("e_no_val2", t_val, 0);
      @(negedge clk);
    end
    chk("e_sb_empty", sb.size(), 0);

    // dBus 1B load at 0xC: word 3, size 1B
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_address = 32'h0000_000C; dbus_cmd_size = 2'd0;
    #1 push_exp(2'b10, 32'h88776655, 1'b0);
    @(negedge clk);
    dbus_cmd_valid = 1'b0;
    chk("b_size", t_size, 3'b000);
    l15_ack = 1'b1; l15_val = 1'b1; l15_rt = 4'd0;
    @(negedge clk);
    l15_ack = 1'b0; l15_val = 1'b0;
    @(negedge clk);
    chk("b_sb_empty", sb.size(), 0);

    // Dropped returns and INT_RET while waiting in RSP
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_address = 32'h0000_0004; dbus_cmd_size = 2'd2;
    #1 push_exp(2'b10, 32'hBEBAFECA, 1'b0);
    @(negedge clk);
    dbus_cmd_valid = 1'b0; l15_ack = 1'b1;
    @(negedge clk);
    l15_ack = 1'b0;
    l15_val = 1'b1; l15_rt = 4'd2; l15_d0 = 64'h0;
    #1 chk("i_ack_other", req_ack, 1);
    @(negedge clk);
    l15_rt = 4'd7; l15_d0 = 64'h0000_0000_0002_0000;
    @(negedge clk);
    chk("i_no_int", vex_int, 0);
    l15_d0 = 64'h0000_0000_0001_0000;
    #1 chk("i_ack_int", req_ack, 1);
    @(negedge clk);
    l15_val = 1'b0;
    chk("i_int", vex_int, 1);
    chk("i_still_rsp", dbus_rsp_valid, 0);
    @(negedge clk);
    chk("i_int_1cyc", vex_int, 0);
    l15_val = 1'b1; l15_rt = 4'd0; l15_d0 = 64'hFFFF_FFFF_CAFE_BABE;
    @(negedge clk);
    l15_val = 1'b0;
    @(negedge clk);
    chk("i_sb_empty", sb.size(), 0);

    // Reset while in REQ
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_0040;
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    chk("r_val", t_val, 1);
    #2 rst_n = 1'b0;
    #1 chk("r_val_async", t_val, 0);
    chk("r_addr_async", t_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    l15_val = 1'b1; l15_rt = 4'd0; l15_ack = 1'b1;
    @(negedge clk);
    l15_val = 1'b0; l15_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("r_no_rsp", {ibus_rsp_valid, dbus_rsp_valid}, 0);
      @(negedge clk);
    end
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_1004;
    #1 chk("r_iready", ibus_cmd_ready, 1);
    push_exp(2'b01, 32'hEFBEADDE, 1'b0);
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    l15_ack = 1'b1; l15_val = 1'b1; l15_rt = 4'd0; l15_d0 = 64'h0000_0000_DEAD_BEEF;
    @(negedge clk);
    l15_ack = 1'b0; l15_val = 1'b0;
    @(negedge clk);
    chk("r_sb_empty", sb.size(), 0);

    // Both buses valid every cycle: round-robin vs dBus priority
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_2000;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_address = 32'h0000_3000; dbus_cmd_size = 2'd2;
    l15_d0 = 64'h01020304_05060708;
    for (int k = 0; k < 3; k++) begin
      expd = (k != 1);
      #1 chk("a_rr_dgrant", dbus_cmd_ready, expd);
      chk("a_rr_igrant", ibus_cmd_ready, !expd);
      chk("a_pri_dgrant", p_dbus_cmd_ready, 1);
      chk("a_pri_igrant", p_ibus_cmd_ready, 0);
      push_exp(expd ? 2'b10 : 2'b01, 32'h04030201, 1'b0);
      @(negedge clk);
      chk("a_busy_ready", {ibus_cmd_ready, dbus_cmd_ready, p_ibus_cmd_ready, p_dbus_cmd_ready}, 0);
      l15_ack = 1'b1;
      @(negedge clk);
      l15_ack = 1'b0; l15_val = 1'b1; l15_rt = 4'd0;
      @(negedge clk);
      l15_val = 1'b0;
      chk("a_pri_rsp", p_dbus_rsp_valid, 1);
      if (k == 2) begin
        ibus_cmd_valid = 1'b0;
        dbus_cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
